sm_alu_seq: RTL
===============

// Module: sm_alu_seq
// PURPOSE
//  Parametrised sign-magnitude ALU for the calculator datapath: add, sub, mul, div, mod.
//  Operands arrive in sign-magnitude format from keypad/BCD logic; internal arithmetic is two's complement.
//  The result returns in sign-magnitude for the display path.
//  Generalises the fixed 18-bit ALU: fixed-latency bit-serial divider, start/busy/done handshake,
//  remainder mode, overflow and divide-by-zero flags.
// PARAMETERS
//  W     18  total operand/result width; bit W-1 = sign, bits W-2:0 = magnitude (MAXM = 2^(W-1)-1)
//  OPW   4   opcode width
// PORTS
//  clk     in   1    clock, rising edge
//  rst_n   in   1    asynchronous, active-low reset
//  start   in   1    request; accepted only when busy=0
//  opcode  in   OPW  10 add, 11 sub, 12 mul, 13 div (quotient), 14 mod (remainder)
//  a, b    in   W    sign-magnitude operands; sampled on the accept cycle only
//  busy    out  1    operation in flight; start is ignored while high
//  done    out  1    one-cycle pulse; result/ovf/dz valid from this cycle
//  result  out  W    sign-magnitude result; held until the next done
//  ovf     out  1    magnitude exceeded MAXM; result saturated to sign|MAXM
//  dz      out  1    div/mod with |b|=0
// BEHAVIOUR
//  Reset: result=0, done=0, busy=0, ovf=0, dz=0. FSM goes to IDLE.
//    A reset mid-operation aborts it with no done pulse.
//  Accept cycle N: start=1, busy=0, opcode in 10..14. Other opcodes: start ignored, no done.
//  Input -0 (sign=1, magnitude=0) is treated as +0. Result is never -0: a zero result has sign 0.
//  add/sub/mul: single cycle, done at N+1, busy never asserted.
//    mul forms a full 2(W-1)-bit magnitude product. ovf=1 if any bit above MAXM is set.
//  div/mod: restoring, one quotient bit per cycle on magnitudes.
//    busy=1 on cycles N+1..N+W-1; done at N+W.
//    Quotient sign = sa^sb (truncating division). Remainder sign = sa.
//  dz: done at N+1, dz=1, ovf=0, result = (sa^sb)|MAXM for div, a unchanged for mod.
//  Flags update only on done. Flags clear on the next done without the condition.
//  On the done cycle busy=0, so start may be accepted again in that cycle (back-to-back).
//  FSM: IDLE -(start, add/sub/mul or dz)-> FIN; IDLE -(start, div/mod)-> DIV;
//    DIV -(count = W-2)-> FIN; FIN -> IDLE with done=1.
//    The single-cycle path keeps busy=0 in FIN.
//  Counter: $clog2(W) bits, cleared on accept.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_ADD..OP_MOD), FSM state encodings,
//    sm2tc/tc2sm conversion functions.
//  Sub-module sm_divider: unsigned W-1-bit restoring divider.
//    Ports: start, dividend, divisor, busy, done, quotient, remainder.
//  Top level: sign logic, add/sub/mul path, saturation, FSM.
// TESTING (W=18, MAXM=0x1FFFF)
//  add +100 (0x00064) + -250 (0x200FA) -> done at N+1, result 0x20096 (-150), ovf=0.
//  sub +131071 - (-1) -> result 0x1FFFF, ovf=1. Next op add 0+0 -> result 0, ovf=0.
//  mul -300 * +400 -> 0x3D4C0 (-120000). Then 1000 * 1000 -> 0x1FFFF, ovf=1.
//  div -100 / +7 -> busy on N+1..N+17, done at N+18, result 0x2000E (-14).
//    mod with the same operands -> 0x20002 (-2).
//  div +5 / -0 -> done at N+1, dz=1, result 0x1FFFF. Start pulses while busy are ignored.
//  Assert rst_n low at N+5 of a div -> no done, all outputs 0. Back-to-back add on the done cycle completes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sign-magnitude calculator ALU: opcodes, FSM
// encodings, debug view and sign-magnitude <-> two's-complement helpers.
package alu_pkg;

   localparam int OP_ADD = 10;
   localparam int OP_SUB = 11;
   localparam int OP_MUL = 12;
   localparam int OP_DIV = 13;
   localparam int OP_MOD = 14;

   // Internal two's-complement width; wide enough for a full W-bit product.
   localparam int MAXW = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   typedef logic signed [MAXW-1:0] tc_t;

   typedef struct packed {
      logic             sgn;
      logic [MAXW-1:0]  mag;
   } sm_t;

   typedef struct packed {
      state_t state;
      logic   div_busy;
      logic   div_done;
   } dbg_t;

   // Sign plus zero-extended magnitude to two's complement; -0 maps to 0.
   function automatic tc_t sm2tc(input logic sgn, input logic [MAXW-1:0] mag);
      tc_t v;
      v = $signed(mag);
      return sgn ? -v : v;
   endfunction

   // Two's complement to sign plus magnitude; zero always comes back positive.
   function automatic sm_t tc2sm(input tc_t v);
      sm_t r;
      r.sgn = v[MAXW-1];
      r.mag = r.sgn ? $unsigned(-v) : $unsigned(v);
      return r;
   endfunction

endpackage

// File: rtl/sm_alu_seq_if.sv
// Request/result bus of the sign-magnitude ALU.
// Handshake: a request is taken on a rising clk edge where start=1, busy=0
// and opcode is a known operation; opcode/a/b are only looked at on that
// edge. done is a one-cycle pulse; result/ovf/dz are valid from the done
// cycle and held until the next done. busy=0 in the done cycle, so a new
// request may be presented in the same cycle.
interface sm_alu_seq_if #(
   parameter int W   = 18,
   parameter int OPW = 4
);
   logic           start;
   logic [OPW-1:0] opcode;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [W-1:0]   result;
   logic           ovf;
   logic           dz;

   modport master (output start, opcode, a, b,
                   input  busy, done, result, ovf, dz);
   modport slave  (input  start, opcode, a, b,
                   output busy, done, result, ovf, dz);
endinterface

// File: rtl/sm_divider.sv
// Unsigned N-bit restoring divider, one quotient bit per clock. The load
// edge already performs the first step, so N-1 further busy cycles follow
// and done pulses in the cycle after the last step.
module sm_divider #(
   parameter int N = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder
);
   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  r_rem, r_q, r_d;
   logic [CW-1:0] r_cnt;
   logic          r_busy, r_done;

   logic          w_load;
   logic [N-1:0]  w_src_rem, w_src_q, w_src_d;
   logic [N:0]    w_sh, w_diff;
   logic          w_ge;

   assign w_load = i_start && !r_busy;

   // One restoring step, fed from the inputs on load and from state otherwise.
   always_comb begin
      w_src_rem = w_load ? '0         : r_rem;
      w_src_q   = w_load ? i_dividend : r_q;
      w_src_d   = w_load ? i_divisor  : r_d;
      w_sh      = {w_src_rem, w_src_q[N-1]};
      w_ge      = (w_sh >= {1'b0, w_src_d});
      w_diff    = w_sh - {1'b0, w_src_d};
   end

   // Step registers, iteration counter and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_q    <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load || r_busy) begin
            r_rem <= w_ge ? w_diff[N-1:0] : w_sh[N-1:0];
            r_q   <= {w_src_q[N-2:0], w_ge};
         end
         if (w_load) begin
            r_d    <= i_divisor;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_quotient  = r_q;
   assign o_remainder = r_rem;
endmodule

// File: rtl/sm_alu_seq.sv
// Sign-magnitude calculator ALU: single-cycle add/sub/mul with saturation,
// multi-cycle truncating div/mod through sm_divider, divide-by-zero flag.
module sm_alu_seq import alu_pkg::*; #(
   parameter int W   = 18,
   parameter int OPW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   sm_alu_seq_if.slave  bus,
   output dbg_t         o_dbg
);
   localparam int M    = W - 1;
   localparam int CNTW = $clog2(W);
   localparam logic [M-1:0] MAXM = '1;

   state_t          r_state, w_next;
   logic [CNTW-1:0] r_cnt;
   logic            r_sa, r_sq, r_mod;
   logic [W-1:0]    r_result;
   logic            r_ovf, r_dz;

   logic            w_is_add, w_is_sub, w_is_mul, w_is_div, w_is_mod;
   logic            w_valid, w_divmod, w_accept, w_dz_hit;
   logic [M-1:0]    w_mag_a, w_mag_b;
   logic            w_sa, w_sb;
   tc_t             w_ta, w_tb, w_tc_res;
   sm_t             w_sm;
   logic            w_sat;
   logic [W-1:0]    w_sc_result, w_dz_result, w_div_result;
   logic [M-1:0]    w_q, w_r;
   logic            w_div_busy, w_div_done;

   // Opcode decode, operand split (-0 becomes +0) and request acceptance.
   always_comb begin
      w_is_add = (bus.opcode == OPW'(OP_ADD));
      w_is_sub = (bus.opcode == OPW'(OP_SUB));
      w_is_mul = (bus.opcode == OPW'(OP_MUL));
      w_is_div = (bus.opcode == OPW'(OP_DIV));
      w_is_mod = (bus.opcode == OPW'(OP_MOD));
      w_valid  = w_is_add || w_is_sub || w_is_mul || w_is_div || w_is_mod;
      w_divmod = w_is_div || w_is_mod;
      w_mag_a  = bus.a[W-2:0];
      w_mag_b  = bus.b[W-2:0];
      w_sa     = bus.a[W-1] && (w_mag_a != '0);
      w_sb     = bus.b[W-1] && (w_mag_b != '0);
      w_accept = bus.start && w_valid && (r_state != ST_DIV);
      w_dz_hit = w_divmod && (w_mag_b == '0);
   end

   // Single-cycle arithmetic in two's complement, then saturate back to sign-magnitude.
   always_comb begin
      w_ta     = sm2tc(w_sa, MAXW'(w_mag_a));
      w_tb     = sm2tc(w_sb, MAXW'(w_mag_b));
      w_tc_res = w_ta + w_tb;
      if (w_is_sub)      w_tc_res = w_ta - w_tb;
      else if (w_is_mul) w_tc_res = w_ta * w_tb;
      w_sm        = tc2sm(w_tc_res);
      w_sat       = (w_sm.mag > MAXW'(MAXM));
      w_sc_result = w_sat ? {w_sm.sgn, MAXM} : {w_sm.sgn, w_sm.mag[M-1:0]};
      w_dz_result = w_is_div ? {w_sa ^ w_sb, MAXM} : {w_sa, w_mag_a};
      w_div_result = r_mod ? {r_sa && (w_r != '0), w_r}
                           : {r_sq && (w_q != '0), w_q};
   end

   sm_divider #(.N(M)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_accept && w_divmod && !w_dz_hit),
      .i_dividend  (w_mag_a),
      .i_divisor   (w_mag_b),
      .o_busy      (w_div_busy),
      .o_done      (w_div_done),
      .o_quotient  (w_q),
      .o_remainder (w_r)
   );

   // Next state and handshake outputs; FIN doubles as IDLE so requests can chain.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_FIN: begin
            w_next = ST_IDLE;
            if (w_accept) w_next = (w_divmod && !w_dz_hit) ? ST_DIV : ST_FIN;
         end
         ST_DIV:  if (r_cnt == CNTW'(W - 2)) w_next = ST_FIN;
         default: w_next = ST_IDLE;
      endcase
      bus.busy       = (r_state == ST_DIV);
      bus.done       = (r_state == ST_FIN);
      bus.result     = r_result;
      bus.ovf        = r_ovf;
      bus.dz         = r_dz;
      o_dbg.state    = r_state;
      o_dbg.div_busy = w_div_busy;
      o_dbg.div_done = w_div_done;
   end

   // State register and divide-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept)                r_cnt <= '0;
         else if (r_state == ST_DIV)  r_cnt <= r_cnt + CNTW'(1);
      end
   end

   // Result and flags change only on the edge that leads into a done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_sa     <= 1'b0;
         r_sq     <= 1'b0;
         r_mod    <= 1'b0;
      end else if (w_accept) begin
         if (!w_divmod) begin
            r_result <= w_sc_result;
            r_ovf    <= w_sat;
            r_dz     <= 1'b0;
         end else if (w_dz_hit) begin
            r_result <= w_dz_result;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b1;
         end else begin
            r_sa  <= w_sa;
            r_sq  <= w_sa ^ w_sb;
            r_mod <= w_is_mod;
         end
      end else if (r_state == ST_DIV && w_div_done) begin
         r_result <= w_div_result;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
      end
   end
endmodule
